// File: rtl/neurosync_pkg.sv
`default_nettype none
// ============================================================
// neurosync_pkg : shared serial-link constants and RX state codes
// Rev 1.0
// ============================================================
package neurosync_pkg;

    localparam int SERIAL_DATA_BITS = 7;
    // 0 selects even parity: XOR over data and parity bit must be 0
    localparam logic SERIAL_PARITY_ODD = 1'b0;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        START    = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        STOP1    = 4'd5,
        STOP2    = 4'd6,
        ARMAZENA = 4'd7,
        RECUPERA = 4'd8
    } rx_state_t;

    function automatic logic parity_error(input logic [SERIAL_DATA_BITS-1:0] d,
                                          input logic p);
        return (^d) ^ p ^ SERIAL_PARITY_ODD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================
// rx_bit_timer : loadable 0..TICKS-1 bit-period counter
// Rev 1.0
// ============================================================
module rx_bit_timer #(
    parameter int TICKS = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic meio,
    output logic fim
);

    localparam int W = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] MEIO_VAL = W'(TICKS/2 - 1);
    localparam logic [W-1:0] FIM_VAL  = W'(TICKS - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (zera)
            count_d = '0;
        else if (conta)
            count_d = (count_q == FIM_VAL) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign meio = (count_q == MEIO_VAL);
    assign fim  = (count_q == FIM_VAL);

endmodule
`default_nettype wire

// File: rtl/neurosync_serial_rx.sv
`default_nettype none
// ============================================================
// neurosync_serial_rx : 7E2 serial receiver with one-entry buffer
// Rev 1.0
// ============================================================
module neurosync_serial_rx
    import neurosync_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        serial,
    input  logic                        recebe,
    output logic [SERIAL_DATA_BITS-1:0] dado,
    output logic                        tem_dado,
    output logic                        pronto,
    output logic                        erro_paridade,
    output logic                        erro_frame,
    output logic                        overrun,
    output logic [3:0]                  db_estado
);

    localparam int TICKS = CLK_FREQ / BAUD;
    localparam int BW    = $clog2(SERIAL_DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(SERIAL_DATA_BITS - 1);

    rx_state_t                   state_q, state_d;
    logic [1:0]                  sync_q;
    logic [BW-1:0]               bit_cnt_q, bit_cnt_d;
    logic [SERIAL_DATA_BITS-1:0] shift_q, shift_d;
    logic                        par_q, par_d;
    logic                        stop1_q, stop1_d;
    logic [SERIAL_DATA_BITS-1:0] dado_q, dado_d;
    logic                        tem_dado_q, tem_dado_d;
    logic                        pronto_q, pronto_d;
    logic                        erro_par_q, erro_par_d;
    logic                        erro_frame_q, erro_frame_d;
    logic                        overrun_q, overrun_d;
    logic                        s, meio, fim, zera_bit, zera;
    logic                        w_ep, w_ef;

    assign s    = sync_q[1];
    assign zera = zera_bit | (state_d != state_q);

    rx_bit_timer #(.TICKS(TICKS)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (1'b1),
        .meio  (meio),
        .fim   (fim)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        stop1_d      = stop1_q;
        dado_d       = dado_q;
        tem_dado_d   = tem_dado_q;
        pronto_d     = 1'b0;
        erro_par_d   = erro_par_q;
        erro_frame_d = erro_frame_q;
        overrun_d    = overrun_q;
        zera_bit     = 1'b0;
        w_ep         = parity_error(shift_q, par_q);
        w_ef         = ~stop1_q | ~s;

        if (recebe) begin
            tem_dado_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            INICIAL:  state_d = ESPERA;
            ESPERA:   if (!s) state_d = START;
            START: begin
                bit_cnt_d = '0;
                if (meio) state_d = s ? ESPERA : DADOS;
            end
            DADOS: if (fim) begin
                shift_d  = {s, shift_q[SERIAL_DATA_BITS-1:1]};
                zera_bit = 1'b1;
                if (bit_cnt_q == LAST_BIT) state_d = PARIDADE;
                else                       bit_cnt_d = bit_cnt_q + 1'b1;
            end
            PARIDADE: if (fim) begin
                par_d   = s;
                state_d = STOP1;
            end
            STOP1: if (fim) begin
                stop1_d = s;
                state_d = STOP2;
            end
            // Results are registered on the STOP2 sample so they appear during ARMAZENA
            STOP2: if (fim) begin
                state_d      = ARMAZENA;
                pronto_d     = 1'b1;
                erro_par_d   = w_ep;
                erro_frame_d = w_ef;
                if (!w_ep && !w_ef) begin
                    dado_d     = shift_q;
                    tem_dado_d = 1'b1;
                    if (tem_dado_q && !recebe) overrun_d = 1'b1;
                end
            end
            ARMAZENA: state_d = s ? ESPERA : RECUPERA;
            RECUPERA: if (s) state_d = ESPERA;
            default:  state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q       <= 2'b11;
            state_q      <= INICIAL;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            stop1_q      <= 1'b1;
            dado_q       <= '0;
            tem_dado_q   <= 1'b0;
            pronto_q     <= 1'b0;
            erro_par_q   <= 1'b0;
            erro_frame_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], serial};
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            stop1_q      <= stop1_d;
            dado_q       <= dado_d;
            tem_dado_q   <= tem_dado_d;
            pronto_q     <= pronto_d;
            erro_par_q   <= erro_par_d;
            erro_frame_q <= erro_frame_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dado          = dado_q;
    assign tem_dado      = tem_dado_q;
    assign pronto        = pronto_q;
    assign erro_paridade = erro_par_q;
    assign erro_frame    = erro_frame_q;
    assign overrun       = overrun_q;
    assign db_estado     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_neurosync_serial_rx.sv
`default_nettype none
// ============================================================
// tb_neurosync_serial_rx : directed 7E2 frame vectors and corner cases
// Rev 1.0
// ============================================================
module tb_neurosync_serial_rx;

    localparam int TICKS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial = 1'b1;
    logic       recebe = 1'b0;
    logic [6:0] dado;
    logic       tem_dado, pronto, erro_paridade, erro_frame, overrun;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    int pronto_cnt = 0;
    bit seen_start = 1'b0;

    always #5 clk = ~clk;

    neurosync_serial_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
        .clock         (clk),
        .reset         (rst_n),
        .serial        (serial),
        .recebe        (recebe),
        .dado          (dado),
        .tem_dado      (tem_dado),
        .pronto        (pronto),
        .erro_paridade (erro_paridade),
        .erro_frame    (erro_frame),
        .overrun       (overrun),
        .db_estado     (db_estado)
    );

    always @(posedge clk) begin
        if (pronto === 1'b1) pronto_cnt = pronto_cnt + 1;
        if (db_estado === 4'd2) seen_start = 1'b1;
    end

    typedef struct {
        bit         ack;
        int         gap;
        logic [6:0] data;
        bit         par;
        logic [6:0] e_dado;
        bit         e_tem;
        bit         e_ep;
        bit         e_ov;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        serial = v;
        repeat (TICKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
        send_bit(s2);
    endtask

    task automatic pulse_recebe();
        @(negedge clk) recebe = 1'b1;
        @(negedge clk) recebe = 1'b0;
    endtask

    initial begin
        int p0;
        vecs[0] = '{1'b0, 2, 7'h35, 1'b0, 7'h35, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1, 7'h41, 1'b1, 7'h35, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1, 7'h12, 1'b0, 7'h12, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 0, 7'h6C, 1'b0, 7'h6C, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1, 7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1, 7'h7F, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {dado, tem_dado, pronto, erro_paridade, erro_frame, overrun, db_estado}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("after_inicial_state", db_estado, 4'd1);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].ack) begin
                pulse_recebe();
                chk($sformatf("v%0d_ack_tem", v), tem_dado, 1'b0);
                chk($sformatf("v%0d_ack_ovr", v), overrun, 1'b0);
            end
            repeat (vecs[v].gap * TICKS) @(negedge clk);
            p0 = pronto_cnt;
            send_frame(vecs[v].data, vecs[v].par, 1'b1);
            chk($sformatf("v%0d_pronto", v), pronto_cnt - p0, 1);
            chk($sformatf("v%0d_dado", v), dado, vecs[v].e_dado);
            chk($sformatf("v%0d_tem", v), tem_dado, vecs[v].e_tem);
            chk($sformatf("v%0d_ep", v), erro_paridade, vecs[v].e_ep);
            chk($sformatf("v%0d_ef", v), erro_frame, 1'b0);
            chk($sformatf("v%0d_ovr", v), overrun, vecs[v].e_ov);
        end

        // Framing error with the line held low afterwards
        repeat (TICKS) @(negedge clk);
        p0 = pronto_cnt;
        send_frame(7'h7F, 1'b1, 1'b0);
        repeat (3 * TICKS) @(negedge clk);
        chk("frm_state_recupera", db_estado, 4'd8);
        chk("frm_erro_frame", erro_frame, 1'b1);
        chk("frm_erro_par", erro_paridade, 1'b0);
        chk("frm_dado_kept", dado, 7'h7F);
        chk("frm_tem_kept", tem_dado, 1'b1);
        serial = 1'b1;
        repeat (2 * TICKS) @(negedge clk);
        chk("frm_back_espera", db_estado, 4'd1);
        chk("frm_one_pronto", pronto_cnt - p0, 1);

        // Short glitch on an idle line
        seen_start = 1'b0;
        p0 = pronto_cnt;
        serial = 1'b0;
        repeat (5) @(negedge clk);
        serial = 1'b1;
        repeat (2 * TICKS) @(negedge clk);
        chk("glitch_saw_start", seen_start, 1'b1);
        chk("glitch_espera", db_estado, 4'd1);
        chk("glitch_no_pronto", pronto_cnt - p0, 0);

        // Reset in the middle of the data bits of 0x55
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (TICKS / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_outputs", {dado, tem_dado, pronto, erro_paridade, erro_frame, overrun, db_estado}, 32'd0);
        serial = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (2 * TICKS) @(negedge clk);
        p0 = pronto_cnt;
        send_frame(7'h2A, 1'b1, 1'b1);
        chk("post_rst_pronto", pronto_cnt - p0, 1);
        chk("post_rst_dado", dado, 7'h2A);
        chk("post_rst_tem", tem_dado, 1'b1);
        chk("post_rst_flags", {erro_paridade, erro_frame, overrun}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
